// File: rtl/ram_bus_arbiter.sv
// Merges the Ibex instruction-fetch and data ports onto a single-port SPRAM.
// Performs address decode, answers out-of-range accesses locally, and routes 1-cycle responses.
module ram_bus_arbiter #(
    parameter logic [31:0] BaseAddr = 32'h0000_0000,
    parameter int unsigned MemBytes = 65536
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,

    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,

    output logic        ram_req_o,
    output logic        ram_we_o,
    output logic [3:0]  ram_be_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_wdata_o,
    input  logic        ram_rvalid_i,
    input  logic [31:0] ram_rdata_i
);

    localparam logic [31:0] OffMask = 32'(MemBytes - 1);

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_INSTR = 2'd1,
        OWN_DATA  = 2'd2
    } owner_e;

    owner_e      r_owner;
    owner_e      w_owner_next;
    logic        r_err;
    logic        w_err_next;
    logic        r_rr;
    logic        w_rr_next;
    logic        r_we;
    logic        w_we_next;

    logic        w_contended;
    logic        w_gnt_instr;
    logic        w_gnt_data;
    logic        w_any_gnt;
    logic [31:0] w_addr;
    logic        w_in_range;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_owner <= OWN_NONE;
            r_err   <= 1'b0;
            r_rr    <= 1'b0;
            r_we    <= 1'b0;
        end else begin
            r_owner <= w_owner_next;
            r_err   <= w_err_next;
            r_rr    <= w_rr_next;
            r_we    <= w_we_next;
        end
    end

    // Grant never looks at the response side, so a new request is accepted every cycle.
    always_comb begin
        w_contended  = instr_req_i & data_req_i;
        w_gnt_data   = data_req_i & (~instr_req_i | ~r_rr);
        w_gnt_instr  = instr_req_i & ~w_gnt_data;
        w_any_gnt    = w_gnt_data | w_gnt_instr;
        w_addr       = w_gnt_data ? data_addr_i : instr_addr_i;
        w_in_range   = (w_addr & ~OffMask) == (BaseAddr & ~OffMask);

        w_rr_next    = w_contended ? w_gnt_data : r_rr;
        w_err_next   = w_any_gnt & ~w_in_range;
        w_we_next    = w_gnt_data & data_we_i;
        w_owner_next = OWN_NONE;
        if (w_gnt_data) begin
            w_owner_next = OWN_DATA;
        end else if (w_gnt_instr) begin
            w_owner_next = OWN_INSTR;
        end

        ram_req_o   = w_any_gnt & w_in_range;
        ram_addr_o  = (w_addr & OffMask) >> 2;
        ram_we_o    = 1'b0;
        ram_be_o    = 4'h0;
        ram_wdata_o = 32'h0;
        if (ram_req_o && w_gnt_data) begin
            ram_we_o    = data_we_i;
            ram_be_o    = data_be_i;
            ram_wdata_o = data_wdata_i;
        end else if (ram_req_o) begin
            ram_be_o    = 4'hF;
        end
    end

    assign instr_gnt_o = w_gnt_instr;
    assign data_gnt_o  = w_gnt_data;

    // Local errors and writes return zero data regardless of what the RAM presents.
    always_comb begin
        instr_rvalid_o = (r_owner == OWN_INSTR);
        data_rvalid_o  = (r_owner == OWN_DATA);
        instr_err_o    = instr_rvalid_o & r_err;
        data_err_o     = data_rvalid_o & r_err;
        instr_rdata_o  = (instr_rvalid_o && !r_err) ? ram_rdata_i : 32'h0;
        data_rdata_o   = (data_rvalid_o && !r_err && !r_we) ? ram_rdata_i : 32'h0;
    end

    a_no_stray_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(ram_rvalid_i && ((r_owner == OWN_NONE) || r_err)));

    a_one_gnt: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(instr_gnt_o && data_gnt_o));

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Randomized bench for ram_bus_arbiter: a transaction-level model predicts grants,
// RAM-side requests and per-port responses; directed literals pin the model.
module tb_ram_bus_arbiter;

    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int unsigned MEM   = 65536;
    localparam int unsigned WORDS = MEM / 4;

    logic        clk_i;
    logic        rst_ni;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        instr_err_o;
    logic        data_req_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;
    logic        ram_req_o;
    logic        ram_we_o;
    logic [3:0]  ram_be_o;
    logic [31:0] ram_addr_o;
    logic [31:0] ram_wdata_o;
    logic        ram_rvalid_i;
    logic [31:0] ram_rdata_i;

    ram_bus_arbiter #(.BaseAddr(BASE), .MemBytes(MEM)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .instr_err_o    (instr_err_o),
        .data_req_i     (data_req_i),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_addr_i    (data_addr_i),
        .data_wdata_i   (data_wdata_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .data_err_o     (data_err_o),
        .ram_req_o      (ram_req_o),
        .ram_we_o       (ram_we_o),
        .ram_be_o       (ram_be_o),
        .ram_addr_o     (ram_addr_o),
        .ram_wdata_o    (ram_wdata_o),
        .ram_rvalid_i   (ram_rvalid_i),
        .ram_rdata_i    (ram_rdata_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // SPRAM model: one-cycle read latency, byte-enabled writes, junk data when not reading.
    logic [31:0] ram_mem [WORDS];
    always @(posedge clk_i) begin
        if (ram_req_o) begin
            ram_rvalid_i <= 1'b1;
            if (ram_we_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_be_o[b]) ram_mem[ram_addr_o % WORDS][8*b +: 8] <= ram_wdata_o[8*b +: 8];
                end
                ram_rdata_i <= $urandom;
            end else begin
                ram_rdata_i <= ram_mem[ram_addr_o % WORDS];
            end
        end else begin
            ram_rvalid_i <= 1'b0;
            ram_rdata_i  <= $urandom;
        end
    end

    typedef struct {
        bit          valid;
        bit          is_data;
        bit          err;
        logic [31:0] rdata;
    } resp_t;

    logic [31:0] model_mem [WORDS];
    resp_t       pend;
    int          contend_cnt;
    int          total;
    int          bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One bus cycle: drive, check against the model mid-cycle, then advance the model.
    task automatic cycle(input bit ir, input logic [31:0] ia, input bit dr, input bit dwe,
                         input logic [3:0] dbe, input logic [31:0] da, input logic [31:0] dwd);
        bit          gi;
        bit          gd;
        bit          inr;
        bit          exp_req;
        logic [31:0] a;
        int          idx;
        @(negedge clk_i);
        instr_req_i  = ir;
        instr_addr_i = ia;
        data_req_i   = dr;
        data_we_i    = dwe;
        data_be_i    = dbe;
        data_addr_i  = da;
        data_wdata_i = dwd;
        #1;
        // Contended grants alternate data, instr, data, ... counted from reset.
        if (ir && dr) begin
            gd = (contend_cnt % 2) == 0;
            gi = !gd;
            contend_cnt++;
        end else begin
            gi = ir;
            gd = dr;
        end
        a       = gd ? da : ia;
        inr     = (a / MEM) == (BASE / MEM);
        idx     = int'((a % MEM) / 4);
        exp_req = (gi || gd) && inr;

        chk("instr_gnt", {31'b0, instr_gnt_o}, {31'b0, gi});
        chk("data_gnt", {31'b0, data_gnt_o}, {31'b0, gd});
        chk("ram_req", {31'b0, ram_req_o}, {31'b0, exp_req});
        if (exp_req) begin
            chk("ram_addr", ram_addr_o, 32'(idx));
            chk("ram_we", {31'b0, ram_we_o}, {31'b0, gd && dwe});
            chk("ram_be", {28'b0, ram_be_o}, gd ? {28'b0, dbe} : 32'hF);
            if (gd) chk("ram_wdata", ram_wdata_o, dwd);
        end else if (!(gi || gd)) begin
            chk("idle_ram_ctl", {27'b0, ram_we_o, ram_be_o}, 32'h0);
            chk("idle_ram_wdata", ram_wdata_o, 32'h0);
        end

        chk("instr_rvalid", {31'b0, instr_rvalid_o}, {31'b0, pend.valid && !pend.is_data});
        chk("data_rvalid", {31'b0, data_rvalid_o}, {31'b0, pend.valid && pend.is_data});
        chk("instr_err", {31'b0, instr_err_o}, {31'b0, pend.valid && !pend.is_data && pend.err});
        chk("data_err", {31'b0, data_err_o}, {31'b0, pend.valid && pend.is_data && pend.err});
        chk("instr_rdata", instr_rdata_o, (pend.valid && !pend.is_data) ? pend.rdata : 32'h0);
        chk("data_rdata", data_rdata_o, (pend.valid && pend.is_data) ? pend.rdata : 32'h0);

        pend.valid   = gi || gd;
        pend.is_data = gd;
        pend.err     = !inr;
        pend.rdata   = (inr && !(gd && dwe)) ? model_mem[idx] : 32'h0;
        if (gd && dwe && inr) begin
            for (int b = 0; b < 4; b++) begin
                if (dbe[b]) model_mem[idx][8*b +: 8] = dwd[8*b +: 8];
            end
        end
    endtask

    task automatic idle();
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic do_reset(input string name);
        @(negedge clk_i);
        rst_ni       = 1'b0;
        instr_req_i  = 1'b0;
        instr_addr_i = 32'h0;
        data_req_i   = 1'b0;
        data_we_i    = 1'b0;
        data_be_i    = 4'h0;
        data_addr_i  = 32'h0;
        data_wdata_i = 32'h0;
        #1;
        chk({name, "_gnts"}, {30'b0, instr_gnt_o, data_gnt_o}, 32'h0);
        chk({name, "_rvalids"}, {30'b0, instr_rvalid_o, data_rvalid_o}, 32'h0);
        chk({name, "_errs"}, {30'b0, instr_err_o, data_err_o}, 32'h0);
        chk({name, "_ram_req"}, {31'b0, ram_req_o}, 32'h0);
        chk({name, "_rdata"}, instr_rdata_o | data_rdata_o, 32'h0);
        pend.valid  = 1'b0;
        contend_cnt = 0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] r;
        if ($urandom_range(0, 9) == 0) begin
            r = {16'($urandom_range(1, 65535)), 16'($urandom)};
        end else begin
            r = {16'h0, 8'h0, 6'($urandom_range(0, 63)), 2'($urandom)};
        end
        return r;
    endfunction

    logic [3:0] alt_pat;

    initial begin
        rst_ni       = 1'b0;
        instr_req_i  = 1'b0;
        instr_addr_i = 32'h0;
        data_req_i   = 1'b0;
        data_we_i    = 1'b0;
        data_be_i    = 4'h0;
        data_addr_i  = 32'h0;
        data_wdata_i = 32'h0;
        pend         = '{valid: 1'b0, is_data: 1'b0, err: 1'b0, rdata: 32'h0};
        contend_cnt  = 0;
        total        = 0;
        bad          = 0;

        do_reset("reset");

        // Fill the working window so later reads return defined data.
        for (int w = 0; w < 64; w++) begin
            cycle(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'(w * 4), $urandom);
        end

        do_reset("reset2");

        // Contention from reset: data, instr, data, instr.
        alt_pat = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 32'h10, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
            chk("alt_data_gnt", {31'b0, data_gnt_o}, {31'b0, alt_pat[k]});
            chk("alt_instr_gnt", {31'b0, instr_gnt_o}, {31'b0, !alt_pat[k]});
        end

        cycle(1'b1, 32'h0000_0010, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("lit_fetch_req", {31'b0, ram_req_o}, 32'h1);
        chk("lit_fetch_addr", ram_addr_o, 32'h4);
        chk("lit_fetch_we", {31'b0, ram_we_o}, 32'h0);

        cycle(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h0000_FFFC, 32'hDEADBEEF);
        chk("lit_fetch_rvalid", {31'b0, instr_rvalid_o}, 32'h1);
        chk("lit_fetch_no_data", {31'b0, data_rvalid_o}, 32'h0);
        chk("lit_wr_addr", ram_addr_o, 32'h3FFF);
        chk("lit_wr_be", {28'b0, ram_be_o}, 32'h3);
        idle();
        chk("lit_wr_rvalid", {31'b0, data_rvalid_o}, 32'h1);
        chk("lit_wr_err", {31'b0, data_err_o}, 32'h0);
        chk("lit_wr_rdata", data_rdata_o, 32'h0);

        cycle(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h0, 32'h1111_1111);
        cycle(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h4, 32'h2222_2222);
        cycle(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h8, 32'h3333_3333);
        cycle(1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("lit_b2b_gnt0", {31'b0, instr_gnt_o}, 32'h1);
        cycle(1'b1, 32'h4, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("lit_b2b_word0", instr_rdata_o, 32'h1111_1111);
        cycle(1'b1, 32'h8, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("lit_b2b_word1", instr_rdata_o, 32'h2222_2222);
        idle();
        chk("lit_b2b_word2", instr_rdata_o, 32'h3333_3333);

        cycle(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h0001_0000, 32'h0);
        chk("lit_oor_gnt", {31'b0, data_gnt_o}, 32'h1);
        chk("lit_oor_req", {31'b0, ram_req_o}, 32'h0);
        idle();
        chk("lit_oor_rvalid", {31'b0, data_rvalid_o}, 32'h1);
        chk("lit_oor_err", {31'b0, data_err_o}, 32'h1);
        chk("lit_oor_rdata", data_rdata_o, 32'h0);

        cycle(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
        do_reset("midrst");
        repeat (3) idle();

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset("rnd_reset");
            end
            cycle($urandom_range(0, 3) != 0, rnd_addr(), $urandom_range(0, 3) != 0,
                  1'($urandom), 4'($urandom), rnd_addr(), $urandom);
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
